hazard_ctrl: RTL

- Pipeline control unit for the 16-bit CPU.
- Sequences the front end by generating the write enables and flush/bubble controls for the PC, the IF-ID pipeline register and the ID-EX pipeline register.
- Resolves three conditions: load-use data hazards (multi-cycle stall), taken branches/jumps resolved in EX (squash), and instruction-memory wait (fetch bubble).
- Sits beside the decode stage; it consumes ID/EX register fields and the fetch handshake.

---
 rtl/cpu_pipe_pkg.sv | 10 +
 rtl/hazard_detect.sv | 20 ++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared pipeline constants and the hazard controller state encoding
package cpu_pipe_pkg;
  localparam int REG_ADDR_W = 3;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LU_STALL   = 2'd1,
    ST_FETCH_WAIT = 2'd2
  } state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between the ID sources and the EX destination
module hazard_detect #(
  parameter int REG_ADDR_W   = 3,
  parameter int R0_HARDWIRED = 1
) (
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic                  i_uses_rs1,
  input  logic                  i_uses_rs2,
  input  logic                  i_mem_read,
  input  logic                  i_reg_write,
  input  logic [REG_ADDR_W-1:0] i_rd,
  output logic                  o_hazard
);
  logic w_match;
  logic w_rd_live;
  assign w_match   = (i_uses_rs1 && i_rs1 == i_rd) || (i_uses_rs2 && i_rs2 == i_rd);
  assign w_rd_live = !(R0_HARDWIRED != 0 && i_rd == '0);
  assign o_hazard  = i_mem_read && i_reg_write && w_match && w_rd_live;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: front-end stall/flush/bubble sequencer; HAZARD_PERF_CNT_EN adds stall/flush counters
module hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int REG_ADDR_W      = cpu_pipe_pkg::REG_ADDR_W,
  parameter int LU_STALL_CYCLES = 1,
  parameter int R0_HARDWIRED    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  imem_ready,
  output logic                  pc_write_enable,
  output logic                  if_id_write_enable,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic [1:0]            ctrl_state,
  output logic [15:0]           perf_stall_cycles,
  output logic [15:0]           perf_flush_count
`else
  output logic [1:0]            ctrl_state
`endif
);
  state_t     r_state;
  state_t     w_nxt_state;
  logic [1:0] r_stall_cnt;
  logic [1:0] w_nxt_cnt;
  logic       w_lu_hazard;

  hazard_detect #(
    .REG_ADDR_W  (REG_ADDR_W),
    .R0_HARDWIRED(R0_HARDWIRED)
  ) u_detect (
    .i_rs1      (id_rs1),
    .i_rs2      (id_rs2),
    .i_uses_rs1 (id_uses_rs1),
    .i_uses_rs2 (id_uses_rs2),
    .i_mem_read (ex_mem_read),
    .i_reg_write(ex_reg_write),
    .i_rd       (ex_rd),
    .o_hazard   (w_lu_hazard)
  );

  assign ctrl_state = r_state;

  // Priority reset > branch > ongoing stall > load-use > fetch wait; the unused encoding behaves as RUN
  always_comb begin
    pc_write_enable    = 1'b0;
    if_id_write_enable = 1'b0;
    if_id_flush        = 1'b0;
    id_ex_bubble       = 1'b0;
    w_nxt_state        = ST_RUN;
    w_nxt_cnt          = '0;
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      pc_write_enable = 1'b1;
      if_id_flush     = 1'b1;
      id_ex_bubble    = 1'b1;
    end else if (r_state == ST_LU_STALL) begin
      id_ex_bubble = 1'b1;
      w_nxt_state  = r_stall_cnt > 2'd1 ? ST_LU_STALL : ST_RUN;
      w_nxt_cnt    = r_stall_cnt > 2'd1 ? r_stall_cnt - 2'd1 : 2'd0;
    end else if (w_lu_hazard) begin
      id_ex_bubble = 1'b1;
      if (r_state == ST_FETCH_WAIT)
        w_nxt_state = ST_FETCH_WAIT;
      else if (LU_STALL_CYCLES > 1) begin
        w_nxt_state = ST_LU_STALL;
        w_nxt_cnt   = 2'(LU_STALL_CYCLES - 1);
      end
    end else if (!imem_ready) begin
      if_id_flush = 1'b1;
      w_nxt_state = ST_FETCH_WAIT;
    end else begin
      pc_write_enable    = 1'b1;
      if_id_write_enable = 1'b1;
    end
  end

  // State and stall counter; reset abandons any stall in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_stall_cnt <= w_nxt_cnt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_perf_stall;
  logic [15:0] r_perf_flush;
  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_count  = r_perf_flush;

  // Saturating counters of PC-hold cycles and taken branches
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (!pc_write_enable && r_perf_stall != 16'hFFFF) r_perf_stall <= r_perf_stall + 16'd1;
      if (ex_branch_taken && r_perf_flush != 16'hFFFF) r_perf_flush <= r_perf_flush + 16'd1;
    end
  end
`endif
endmodule
